// File: rtl/puf_ro_counter.sv
// puf_ro_counter: measurement front-end of the PUF datapath.
// Synchronises two ring-oscillator outputs, counts their rising edges over a
// programmable gate window and hands both counts to the comparator stage,
// holding comp_en until the comparator reports done.
module puf_ro_counter #(
  parameter int CNT_W       = 32,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic             abort,
  input  logic             ro_a,
  input  logic             ro_b,
  input  logic             comp_done,
  output logic [CNT_W-1:0] num1,
  output logic [CNT_W-1:0] num2,
  output logic             comp_en,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

  // Saturating increment: returns {overflow_hit, next_value}. A counter
  // already at full scale keeps its value and flags the lost edge.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] value,
                                             input logic             edge_hit);
    logic [CNT_W:0] result;
    if (!edge_hit) begin
      result = {1'b0, value};
    end else if (value == CNT_MAX) begin
      result = {1'b1, value};
    end else begin
      result = {1'b0, value + {{(CNT_W-1){1'b0}}, 1'b1}};
    end
    return result;
  endfunction

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [WIN_W-1:0]       win_cnt_r;
  logic [SYNC_STAGES-1:0] sync_a_r;
  logic [SYNC_STAGES-1:0] sync_b_r;
  logic                   prev_a_r;
  logic                   prev_b_r;
  logic                   edge_a_s;
  logic                   edge_b_s;
  logic [CNT_W:0]         inc_a_s;
  logic [CNT_W:0]         inc_b_s;
  logic                   comp_en_nxt_s;
  logic                   busy_nxt_s;

  // Metastability chains and previous-sample flops; free-running in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a_r <= {SYNC_STAGES{1'b0}};
      sync_b_r <= {SYNC_STAGES{1'b0}};
      prev_a_r <= 1'b0;
      prev_b_r <= 1'b0;
    end else begin
      sync_a_r <= {sync_a_r[SYNC_STAGES-2:0], ro_a};
      sync_b_r <= {sync_b_r[SYNC_STAGES-2:0], ro_b};
      prev_a_r <= sync_a_r[SYNC_STAGES-1];
      prev_b_r <= sync_b_r[SYNC_STAGES-1];
    end
  end

  // Rising-edge detect on the synchronised samples plus saturating next counts.
  always_comb begin
    edge_a_s = sync_a_r[SYNC_STAGES-1] & ~prev_a_r;
    edge_b_s = sync_b_r[SYNC_STAGES-1] & ~prev_b_r;
    inc_a_s  = sat_inc(num1, edge_a_s);
    inc_b_s  = sat_inc(num2, edge_b_s);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; abort outranks comp_done, start outranks abort in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (window_len == WIN_ZERO) begin
            state_nxt_s = PRESENT;
          end else begin
            state_nxt_s = COUNT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COUNT: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (win_cnt_r == WIN_ONE) begin
          state_nxt_s = PRESENT;
        end else begin
          state_nxt_s = COUNT;
        end
      end
      PRESENT: begin
        if (abort || comp_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PRESENT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM output decode from the next state so the registered flags line up with it.
  always_comb begin
    comp_en_nxt_s = (state_nxt_s == PRESENT);
    busy_nxt_s    = (state_nxt_s != IDLE);
  end

  // Registered outputs, window down-counter and edge counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      comp_en   <= 1'b0;
      busy      <= 1'b0;
      num1      <= CNT_ZERO;
      num2      <= CNT_ZERO;
      ovf       <= 1'b0;
      win_cnt_r <= WIN_ZERO;
    end else begin
      comp_en <= comp_en_nxt_s;
      busy    <= busy_nxt_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            num1      <= CNT_ZERO;
            num2      <= CNT_ZERO;
            ovf       <= 1'b0;
            win_cnt_r <= window_len;
          end else begin
            win_cnt_r <= win_cnt_r;
          end
        end
        COUNT: begin
          if (abort) begin
            num1      <= CNT_ZERO;
            num2      <= CNT_ZERO;
            ovf       <= 1'b0;
            win_cnt_r <= WIN_ZERO;
          end else begin
            num1      <= inc_a_s[CNT_W-1:0];
            num2      <= inc_b_s[CNT_W-1:0];
            win_cnt_r <= win_cnt_r - WIN_ONE;
            if (inc_a_s[CNT_W] || inc_b_s[CNT_W]) begin
              ovf <= 1'b1;
            end else begin
              ovf <= ovf;
            end
          end
        end
        PRESENT: begin
          if (abort) begin
            num1 <= CNT_ZERO;
            num2 <= CNT_ZERO;
            ovf  <= 1'b0;
          end else begin
            num1 <= num1;
            num2 <= num2;
          end
        end
        default: begin
          win_cnt_r <= WIN_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_ro_counter.sv
// Testbench for puf_ro_counter: scoreboard of expected counts per measurement,
// popped and compared when comp_en rises. A second instance with 4-bit
// counters exercises saturation.
module tb_puf_ro_counter;

  typedef struct {
    int n1;
    int n2;
    int tol;
    bit ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] window_len = 16'd0;
  logic        abort = 1'b0;
  logic        ro_a = 1'b0;
  logic        ro_b = 1'b0;
  logic        comp_done = 1'b0;
  logic [31:0] num1, num2;
  logic        comp_en, busy, ovf;

  logic        start_s = 1'b0;
  logic [15:0] win_s = 16'd0;
  logic        abort_s = 1'b0;
  logic        ro_s = 1'b0;
  logic        ro_zero = 1'b0;
  logic        done_s = 1'b0;
  logic [3:0]  num1_s, num2_s;
  logic        comp_en_s, busy_s, ovf_s;

  int   pa = 0, pb = 0, ps = 0;
  int   n_checks = 0, n_fail = 0;
  exp_t sb[$];

  puf_ro_counter dut (
    .clk(clk), .rst(rst), .start(start), .window_len(window_len), .abort(abort),
    .ro_a(ro_a), .ro_b(ro_b), .comp_done(comp_done),
    .num1(num1), .num2(num2), .comp_en(comp_en), .busy(busy), .ovf(ovf)
  );

  puf_ro_counter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .window_len(win_s), .abort(abort_s),
    .ro_a(ro_s), .ro_b(ro_zero), .comp_done(done_s),
    .num1(num1_s), .num2(num2_s), .comp_en(comp_en_s), .busy(busy_s), .ovf(ovf_s)
  );

  always #5 clk = ~clk;

  // Oscillator models: period in clk cycles, 0 = stopped low; change on negedge.
  initial begin
    int ca = 0, cb = 0, cs = 0;
    forever begin
      @(negedge clk);
      if (pa == 0) begin ro_a = 1'b0; ca = 0; end
      else begin ca = (ca + 1 >= pa) ? 0 : ca + 1; ro_a = (ca < pa / 2); end
      if (pb == 0) begin ro_b = 1'b0; cb = 0; end
      else begin cb = (cb + 1 >= pb) ? 0 : cb + 1; ro_b = (cb < pb / 2); end
      if (ps == 0) begin ro_s = 1'b0; cs = 0; end
      else begin cs = (cs + 1 >= ps) ? 0 : cs + 1; ro_s = (cs < ps / 2); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for comp_en (main or saturating instance) within a cycle budget.
  task automatic wait_en(input bit sat, input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget && !ok) begin
      tick();
      cycles++;
      if ((sat ? comp_en_s : comp_en) === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_start(input logic [15:0] len);
    window_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_present();
    comp_done = 1'b1;
    tick();
    comp_done = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    n_checks++;
    if (num1 !== 32'd0 || num2 !== 32'd0 || comp_en !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: num1=%0d num2=%0d comp_en=%b busy=%b ovf=%b, expected all 0",
               num1, num2, comp_en, busy, ovf);
    end
    repeat (3) tick();
    rst = 1'b1;
    pa = 4; pb = 5;
    tick();
    pulse_start(16'd50);
    repeat (10) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_precond_busy: got %b expected 1", busy);
    end
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (num1 !== 32'd0 || num2 !== 32'd0 || comp_en !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: num1=%0d num2=%0d comp_en=%b busy=%b ovf=%b, expected all 0",
               num1, num2, comp_en, busy, ovf);
    end
    tick();
    rst = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (comp_en !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_no_pulse: comp_en/busy went high after release, expected 0");
    end
  endtask

  task automatic test_window();
    int cyc;
    bit ok;
    exp_t e;
    logic [31:0] h1;
    sb.push_back('{n1: 25, n2: 20, tol: 1, ovf: 1'b0});
    pulse_start(16'd100);
    n_checks++;
    if (busy !== 1'b1 || comp_en !== 1'b0) begin
      n_fail++;
      $display("FAIL window_accept: busy=%b comp_en=%b expected 1/0", busy, comp_en);
    end
    wait_en(1'b0, 300, cyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cyc != 100) begin
      n_fail++;
      $display("FAIL window_len_cycles: got %0d (ok=%b) expected 100", cyc, ok);
    end
    n_checks++;
    if (int'(num1) > e.n1 + e.tol || int'(num1) + e.tol < e.n1 ||
        int'(num2) > e.n2 + e.tol || int'(num2) + e.tol < e.n2 || ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL window_counts: num1=%0d num2=%0d ovf=%b expected %0d/%0d (+/-%0d) ovf=%b",
               num1, num2, ovf, e.n1, e.n2, e.tol, e.ovf);
    end
    h1 = num1;
    finish_present();
    n_checks++;
    if (comp_en !== 1'b0 || busy !== 1'b0 || num1 !== h1) begin
      n_fail++;
      $display("FAIL window_done_drop: comp_en=%b busy=%b num1=%0d expected 0/0/%0d",
               comp_en, busy, num1, h1);
    end
  endtask

  task automatic test_zero_window();
    int cyc;
    bit ok;
    exp_t e;
    sb.push_back('{n1: 0, n2: 0, tol: 0, ovf: 1'b0});
    window_len = 16'd0;
    start = 1'b1;
    wait_en(1'b0, 1, cyc, ok);
    start = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (!ok || busy !== 1'b1 || int'(num1) != e.n1 || int'(num2) != e.n2 || ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL zero_window: comp_en=%b busy=%b num1=%0d num2=%0d ovf=%b expected 1/1/%0d/%0d/%b",
               comp_en, busy, num1, num2, ovf, e.n1, e.n2, e.ovf);
    end
    finish_present();
  endtask

  task automatic test_saturate();
    int cyc;
    bit ok;
    exp_t e;
    ps = 2;
    sb.push_back('{n1: 15, n2: 0, tol: 0, ovf: 1'b1});
    win_s = 16'd64;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    wait_en(1'b1, 200, cyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(num1_s) != e.n1 || int'(num2_s) != e.n2 || ovf_s !== e.ovf) begin
      n_fail++;
      $display("FAIL saturate: ok=%b num1=%0d num2=%0d ovf=%b expected %0d/%0d/%b",
               ok, num1_s, num2_s, ovf_s, e.n1, e.n2, e.ovf);
    end
    done_s = 1'b1;
    tick();
    done_s = 1'b0;
    n_checks++;
    if (ovf_s !== 1'b1 || num1_s !== 4'd15) begin
      n_fail++;
      $display("FAIL saturate_idle_hold: ovf=%b num1=%0d expected 1/15", ovf_s, num1_s);
    end
    sb.push_back('{n1: 0, n2: 0, tol: 0, ovf: 1'b0});
    win_s = 16'd0;
    start_s = 1'b1;
    wait_en(1'b1, 1, cyc, ok);
    start_s = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (!ok || ovf_s !== e.ovf || int'(num1_s) != e.n1) begin
      n_fail++;
      $display("FAIL saturate_ovf_clear: ok=%b ovf=%b num1=%0d expected ovf=%b num1=%0d",
               ok, ovf_s, num1_s, e.ovf, e.n1);
    end
    done_s = 1'b1;
    tick();
    done_s = 1'b0;
    ps = 0;
  endtask

  task automatic test_abort();
    int cyc;
    bit ok, seen;
    exp_t e;
    pulse_start(16'd100);
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || comp_en !== 1'b0 || num1 !== 32'd0 || num2 !== 32'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_count: busy=%b comp_en=%b num1=%0d num2=%0d ovf=%b expected all 0",
               busy, comp_en, num1, num2, ovf);
    end
    seen = 1'b0;
    repeat (110) begin
      tick();
      if (comp_en !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_comp_en: comp_en rose after abort, expected 0");
    end
    sb.push_back('{n1: 5, n2: 4, tol: 1, ovf: 1'b0});
    pulse_start(16'd20);
    wait_en(1'b0, 60, cyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || int'(num1) > e.n1 + e.tol || int'(num1) + e.tol < e.n1 ||
        int'(num2) > e.n2 + e.tol || int'(num2) + e.tol < e.n2) begin
      n_fail++;
      $display("FAIL abort_pre_counts: ok=%b num1=%0d num2=%0d expected %0d/%0d (+/-%0d)",
               ok, num1, num2, e.n1, e.n2, e.tol);
    end
    abort = 1'b1;
    comp_done = 1'b1;
    tick();
    abort = 1'b0;
    comp_done = 1'b0;
    n_checks++;
    if (num1 !== 32'd0 || num2 !== 32'd0 || comp_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_and_done: num1=%0d num2=%0d comp_en=%b busy=%b expected all 0",
               num1, num2, comp_en, busy);
    end
    sb.push_back('{n1: 2, n2: 2, tol: 1, ovf: 1'b0});
    window_len = 16'd8;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_beats_abort: busy=%b expected 1", busy);
    end
    wait_en(1'b0, 30, cyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cyc != 8 || int'(num1) > e.n1 + e.tol || int'(num1) + e.tol < e.n1) begin
      n_fail++;
      $display("FAIL start_abort_window: ok=%b cycles=%0d num1=%0d expected 8 cycles, %0d (+/-%0d)",
               ok, cyc, num1, e.n1, e.tol);
    end
    finish_present();
  endtask

  task automatic test_protocol();
    int cyc;
    bit ok, bad;
    exp_t e;
    logic [31:0] h1, h2;
    sb.push_back('{n1: 15, n2: 12, tol: 1, ovf: 1'b0});
    pulse_start(16'd60);
    cyc = 0;
    ok = 1'b0;
    while (cyc < 200 && !ok) begin
      start = (cyc == 10);
      if (cyc == 10) window_len = 16'd5;
      tick();
      cyc++;
      if (comp_en === 1'b1) ok = 1'b1;
    end
    start = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (!ok || cyc != 60) begin
      n_fail++;
      $display("FAIL protocol_window: got %0d cycles (ok=%b) expected 60", cyc, ok);
    end
    n_checks++;
    if (int'(num1) > e.n1 + e.tol || int'(num1) + e.tol < e.n1 ||
        int'(num2) > e.n2 + e.tol || int'(num2) + e.tol < e.n2) begin
      n_fail++;
      $display("FAIL protocol_counts: num1=%0d num2=%0d expected %0d/%0d (+/-%0d)",
               num1, num2, e.n1, e.n2, e.tol);
    end
    h1 = num1;
    h2 = num2;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      start = (i == 20);
      window_len = 16'd0;
      tick();
      if (comp_en !== 1'b1 || busy !== 1'b1 || num1 !== h1 || num2 !== h2) bad = 1'b1;
    end
    start = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL protocol_hold: comp_en=%b num1=%0d num2=%0d expected 1/%0d/%0d",
               comp_en, num1, num2, h1, h2);
    end
    finish_present();
    n_checks++;
    if (comp_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL protocol_release: comp_en=%b busy=%b expected 0/0", comp_en, busy);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_window();
    test_zero_window();
    test_saturate();
    test_abort();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
